// File: rtl/age_iq.sv
// age_iq: age-matrix out-of-order issue queue that feeds a single execution pipe.
// Define IQ_WKUP_OUT_EN to enable the early-wakeup output port.
module age_iq #(
  parameter int IQ_SIZE      = 8,
  parameter int DISPATCH_CNT = 2,
  parameter int REG_COUNT    = 2,
  parameter int CDB_COUNT    = 2,
  parameter int DATA_W       = 32,
  parameter int TAG_W        = 6,
  parameter int PAYLOAD_W    = 64
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              flush,
  input  logic [DISPATCH_CNT-1:0]                           disp_valid_i,
  input  logic [DISPATCH_CNT-1:0][PAYLOAD_W-1:0]            disp_payload_i,
  input  logic [DISPATCH_CNT-1:0][TAG_W-1:0]                disp_dst_tag_i,
  input  logic [DISPATCH_CNT-1:0][REG_COUNT-1:0][TAG_W-1:0] disp_src_tag_i,
  input  logic [DISPATCH_CNT-1:0][REG_COUNT-1:0]            disp_src_rdy_i,
  input  logic [DISPATCH_CNT-1:0][REG_COUNT-1:0][DATA_W-1:0] disp_src_data_i,
  output logic                                              disp_ready_o,
  output logic [$clog2(IQ_SIZE+1)-1:0]                      free_cnt_o,
  input  logic [CDB_COUNT-1:0]                              cdb_valid_i,
  input  logic [CDB_COUNT-1:0][TAG_W-1:0]                   cdb_tag_i,
  input  logic [CDB_COUNT-1:0][DATA_W-1:0]                  cdb_data_i,
  output logic                                              iss_valid_o,
  input  logic                                              iss_ready_i,
  output logic [PAYLOAD_W-1:0]                              iss_payload_o,
  output logic [TAG_W-1:0]                                  iss_dst_tag_o,
  output logic [REG_COUNT-1:0][DATA_W-1:0]                  iss_src_data_o,
  output logic                                              wkup_valid_o,
  output logic [TAG_W-1:0]                                  wkup_tag_o
);

  localparam int FREE_W = $clog2(IQ_SIZE + 1);
  localparam int IDX_W  = $clog2(IQ_SIZE);
  localparam int LANE_W = (DISPATCH_CNT > 1) ? $clog2(DISPATCH_CNT) : 1;
  localparam logic [FREE_W-1:0] FREE_FULL = FREE_W'(IQ_SIZE);
  localparam logic [FREE_W-1:0] FREE_NEED = FREE_W'(DISPATCH_CNT);

  logic [IQ_SIZE-1:0]                   valid_q;
  logic [PAYLOAD_W-1:0]                 payload_q [IQ_SIZE];
  logic [TAG_W-1:0]                     dst_q     [IQ_SIZE];
  logic [REG_COUNT-1:0][TAG_W-1:0]      stag_q    [IQ_SIZE];
  logic [REG_COUNT-1:0]                 srdy_q    [IQ_SIZE];
  logic [REG_COUNT-1:0][DATA_W-1:0]     sdata_q   [IQ_SIZE];
  logic [IQ_SIZE-1:0]                   age_q     [IQ_SIZE];

  logic                                 iss_valid_q;
  logic [PAYLOAD_W-1:0]                 iss_payload_q;
  logic [TAG_W-1:0]                     iss_dst_q;
  logic [REG_COUNT-1:0][DATA_W-1:0]     iss_data_q;
  logic [FREE_W-1:0]                    free_q;
  logic                                 disp_ready_q;

  logic [REG_COUNT-1:0]                 ent_rdy_w  [IQ_SIZE];
  logic [REG_COUNT-1:0][DATA_W-1:0]     ent_data_w [IQ_SIZE];
  logic [DISPATCH_CNT-1:0][REG_COUNT-1:0]             lane_rdy_w;
  logic [DISPATCH_CNT-1:0][REG_COUNT-1:0][DATA_W-1:0] lane_data_w;
  logic [IQ_SIZE-1:0]                   new_mask;
  logic [LANE_W-1:0]                    new_lane [IQ_SIZE];
  logic [FREE_W-1:0]                    alloc_cnt;
  logic [IQ_SIZE-1:0]                   ready_ent;
  logic [IQ_SIZE-1:0]                   sel;
  logic [IDX_W-1:0]                     sel_idx;
  logic                                 any_sel;
  logic                                 iss_take;
  logic                                 load;
  logic [FREE_W-1:0]                    free_next;

  // CDB capture; buses scanned high-to-low so the lowest matching index wins.
  always_comb begin
    for (int i = 0; i < IQ_SIZE; i++) begin
      ent_rdy_w[i]  = srdy_q[i];
      ent_data_w[i] = sdata_q[i];
      for (int r = 0; r < REG_COUNT; r++) begin
        if (!srdy_q[i][r]) begin
          for (int b = CDB_COUNT - 1; b >= 0; b--) begin
            if (cdb_valid_i[b] && (cdb_tag_i[b] == stag_q[i][r])) begin
              ent_rdy_w[i][r]  = 1'b1;
              ent_data_w[i][r] = cdb_data_i[b];
            end
          end
        end
      end
    end
  end

  always_comb begin
    lane_rdy_w  = disp_src_rdy_i;
    lane_data_w = disp_src_data_i;
    for (int k = 0; k < DISPATCH_CNT; k++) begin
      for (int r = 0; r < REG_COUNT; r++) begin
        if (!disp_src_rdy_i[k][r]) begin
          for (int b = CDB_COUNT - 1; b >= 0; b--) begin
            if (cdb_valid_i[b] && (cdb_tag_i[b] == disp_src_tag_i[k][r])) begin
              lane_rdy_w[k][r]  = 1'b1;
              lane_data_w[k][r] = cdb_data_i[b];
            end
          end
        end
      end
    end
  end

  // Pack accepted lanes onto the lowest free entries, in lane order.
  always_comb begin
    logic [IQ_SIZE-1:0] avail;
    logic               found;
    avail     = ~valid_q;
    new_mask  = '0;
    alloc_cnt = '0;
    found     = 1'b0;
    for (int i = 0; i < IQ_SIZE; i++) new_lane[i] = '0;
    for (int k = 0; k < DISPATCH_CNT; k++) begin
      found = 1'b0;
      if (disp_valid_i[k] && disp_ready_q && !flush) begin
        for (int i = 0; i < IQ_SIZE; i++) begin
          if (!found && avail[i]) begin
            found       = 1'b1;
            avail[i]    = 1'b0;
            new_mask[i] = 1'b1;
            new_lane[i] = LANE_W'(k);
          end
        end
      end
      if (found) alloc_cnt = alloc_cnt + FREE_W'(1);
    end
  end

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < IQ_SIZE; i++) ready_ent[i] = valid_q[i] & (&srdy_q[i]);
    for (int i = 0; i < IQ_SIZE; i++) begin
      sel[i] = ready_ent[i];
      for (int j = 0; j < IQ_SIZE; j++) begin
        if (ready_ent[j] && age_q[j][i]) sel[i] = 1'b0;
      end
    end
    for (int i = 0; i < IQ_SIZE; i++) begin
      if (sel[i]) sel_idx = IDX_W'(i);
    end
  end

  assign any_sel   = |sel;
  assign iss_take  = !iss_valid_q || iss_ready_i;
  assign load      = iss_take && any_sel && !flush;
  assign free_next = free_q - alloc_cnt + FREE_W'(load);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q       <= '0;
      iss_valid_q   <= 1'b0;
      iss_payload_q <= '0;
      iss_dst_q     <= '0;
      iss_data_q    <= '0;
      free_q        <= FREE_FULL;
      disp_ready_q  <= 1'b1;
      for (int i = 0; i < IQ_SIZE; i++) begin
        payload_q[i] <= '0;
        dst_q[i]     <= '0;
        stag_q[i]    <= '0;
        srdy_q[i]    <= '0;
        sdata_q[i]   <= '0;
        age_q[i]     <= '0;
      end
    end else if (flush) begin
      valid_q      <= '0;
      iss_valid_q  <= 1'b0;
      free_q       <= FREE_FULL;
      disp_ready_q <= 1'b1;
    end else begin
      for (int i = 0; i < IQ_SIZE; i++) begin
        if (new_mask[i]) begin
          valid_q[i]   <= 1'b1;
          payload_q[i] <= disp_payload_i[new_lane[i]];
          dst_q[i]     <= disp_dst_tag_i[new_lane[i]];
          stag_q[i]    <= disp_src_tag_i[new_lane[i]];
          srdy_q[i]    <= lane_rdy_w[new_lane[i]];
          sdata_q[i]   <= lane_data_w[new_lane[i]];
        end else begin
          srdy_q[i]  <= ent_rdy_w[i];
          sdata_q[i] <= ent_data_w[i];
          if (load && sel[i]) valid_q[i] <= 1'b0;
        end
        // New rows: older only than later lanes of the same cycle; new columns: every valid entry is older.
        for (int j = 0; j < IQ_SIZE; j++) begin
          if (new_mask[i] && new_mask[j]) age_q[i][j] <= (new_lane[i] < new_lane[j]);
          else if (new_mask[i])           age_q[i][j] <= 1'b0;
          else if (new_mask[j])           age_q[i][j] <= valid_q[i];
        end
      end
      if (iss_take) begin
        iss_valid_q <= any_sel;
        if (any_sel) begin
          iss_payload_q <= payload_q[sel_idx];
          iss_dst_q     <= dst_q[sel_idx];
          iss_data_q    <= sdata_q[sel_idx];
        end
      end
      free_q       <= free_next;
      disp_ready_q <= (free_next >= FREE_NEED);
    end
  end

  assign disp_ready_o   = disp_ready_q;
  assign free_cnt_o     = free_q;
  assign iss_valid_o    = iss_valid_q;
  assign iss_payload_o  = iss_payload_q;
  assign iss_dst_tag_o  = iss_dst_q;
  assign iss_src_data_o = iss_data_q;

`ifdef IQ_WKUP_OUT_EN
  assign wkup_valid_o = load;
  assign wkup_tag_o   = load ? dst_q[sel_idx] : '0;
`else
  assign wkup_valid_o = 1'b0;
  assign wkup_tag_o   = '0;
`endif

endmodule

// File: doc/age_iq.md
# age_iq

Parametrised out-of-order issue queue: the generalised successor of the single-ALU IQ. It accepts up to DISPATCH_CNT instructions per cycle and captures source operands from CDB_COUNT broadcast buses. Each cycle it selects the oldest fully-ready entry using an age matrix and presents it through a registered valid/ready issue port to one execution unit. It sits between dispatch and an execution pipe (ALU, MUL, LSU-address), one instance per pipe.

## Interface
Parameters:
- IQ_SIZE, 8: number of entries; any value ≥ 2, not restricted to powers of two.
- DISPATCH_CNT, 2: dispatch lanes per cycle; 1..IQ_SIZE.
- REG_COUNT, 2: source operands per instruction.
- CDB_COUNT, 2: wakeup/broadcast buses.
- DATA_W, 32: operand width.
- TAG_W, 6: physical/ROB tag width.
- PAYLOAD_W, 64: opaque decode payload width, carried unmodified.

Ports:
- clk, in, 1: single clock; all state updates on the rising edge.
- rst, in, 1: asynchronous, active-high reset.
- flush, in, 1: synchronous; drops all entries and the issue register at the next edge.
- disp_valid_i, in, DISPATCH_CNT: per-lane dispatch request.
- disp_payload_i, in, DISPATCH_CNT×PAYLOAD_W: decode payload.
- disp_dst_tag_i, in, DISPATCH_CNT×TAG_W: destination tag.
- disp_src_tag_i, in, DISPATCH_CNT×REG_COUNT×TAG_W: source tags.
- disp_src_rdy_i, in, DISPATCH_CNT×REG_COUNT: source operand already available.
- disp_src_data_i, in, DISPATCH_CNT×REG_COUNT×DATA_W: source data, valid when rdy is set.
- disp_ready_o, out, 1: registered; high when free entries ≥ DISPATCH_CNT.
- free_cnt_o, out, $clog2(IQ_SIZE+1): registered free-entry count.
- cdb_valid_i, in, CDB_COUNT: broadcast valid.
- cdb_tag_i, in, CDB_COUNT×TAG_W: broadcast tag.
- cdb_data_i, in, CDB_COUNT×DATA_W: broadcast data.
- iss_valid_o, out, 1: issue register holds an instruction.
- iss_ready_i, in, 1: execution unit accepts the issue register contents.
- iss_payload_o, out, PAYLOAD_W: issued payload.
- iss_dst_tag_o, out, TAG_W: issued destination tag.
- iss_src_data_o, out, REG_COUNT×DATA_W: issued operands.
- wkup_valid_o, out, 1: early-wakeup pulse (see Configuration).
- wkup_tag_o, out, TAG_W: early-wakeup tag.

## Operation
- Entry state: valid, payload, dst tag, and per source {tag, rdy, data}. An age matrix holds age[i][j]=1 when entry i is older than entry j.
- Allocation:
  - Dispatch lanes with disp_valid_i set are packed onto the lowest-index free entries in lane order.
  - A new entry is younger than every valid entry. Same-cycle lane k is older than lane k+1.
  - Asserting disp_valid_i while disp_ready_o=0 is illegal. The bench asserts on it, and the design ignores the request.
- Wakeup:
  - For each valid entry source with rdy=0, a match on any cdb_valid_i/cdb_tag_i captures cdb_data_i and sets rdy at the edge.
  - Dispatching sources are also compared against the CDB in their dispatch cycle, so a same-cycle broadcast is never missed.
  - If multiple CDB buses match the same tag, the lowest bus index wins.
- Ready: an entry is ready when it is valid and every registered source rdy bit is 1.
- Select: choose the ready entry i for which no ready j has age[j][i]=1. The result is at most one-hot.
- Issue register:
  - Loads the selected entry when iss_valid_o=0 or iss_ready_i=1.
  - The loaded entry's valid bit is cleared at the same edge.
  - If nothing is selected while the register drains (iss_ready_i=1), iss_valid_o falls.
- Free count: free_next = free − accepted_dispatches + loaded_into_issue_reg.
  - disp_ready_o ≤ (free_next ≥ DISPATCH_CNT).
  - free_cnt_o ≤ free_next.
- Flush (no reset): clears all entry valids and iss_valid_o; free=IQ_SIZE; disp_ready_o=1. Dispatches in the flush cycle are discarded.
- Reset (asynchronous, may hit mid-operation): same state as flush, applied immediately. Outputs return to their reset values while rst is high.

## Timing
- Reset values: iss_valid_o=0, disp_ready_o=1, free_cnt_o=IQ_SIZE, wkup_valid_o=0. All data outputs are 0.
- Dispatch with all sources ready in cycle c: selectable in c+1, iss_valid_o=1 in c+2.
- CDB match in cycle c on the last missing source: selectable in c+1, issued in c+2.
- Backpressure: while iss_valid_o=1 and iss_ready_i=0, the issue outputs hold stable and no entry is freed.
- Full: at free=DISPATCH_CNT−1 or less, disp_ready_o=0 from the next cycle.
  - When dispatch and issue happen in the same cycle, the issue's returned slot counts in free_next.
- Age matrix: has no counters, so there is no saturation or wrap-around. Ordering stays correct indefinitely.

## Configuration
- IQ_WKUP_OUT_EN defined:
  - wkup_valid_o is asserted combinationally in the cycle an entry is loaded into the issue register, with wkup_tag_o = that entry's dst tag.
  - Forced to 0 in a flush cycle.
- Not defined: wkup_valid_o=0 and wkup_tag_o=0 constantly, and the early-wakeup logic is absent.

## Test plan
- Reset, then dispatch two ready instructions (tags 5, 6) on lanes 0/1 in cycle 1 → iss_dst_tag_o=5 in cycle 3, then 6 in cycle 4 with iss_ready_i=1.
- IQ_SIZE=8, DISPATCH_CNT=2: fill with 8 non-ready entries → disp_ready_o=0 once free<2 and free_cnt_o=0. One CDB wakeup plus issue → free_cnt_o=1, disp_ready_o stays 0.
- Entries A (older, src tag 9) and B (younger, src tag 10): CDB tag 10 in cycle c, then tag 9 in c+1 → B issues first. With both broadcast in the same cycle → A issues first.
- Dispatch with src tag 3 not ready while cdb_tag_i[1]=3, data 0xDEADBEEF, same cycle → issues with iss_src_data_o[0]=0xDEADBEEF, no extra delay.
- Hold iss_ready_i=0 for 4 cycles with 3 ready entries → issue outputs stable and free_cnt_o unchanged. Release → one issue per cycle, in age order.
- Assert flush, then separately rst asynchronously mid-traffic → iss_valid_o=0, free_cnt_o=8, disp_ready_o=1. With IQ_WKUP_OUT_EN, wkup_valid_o=0 during the flush cycle.
